// File: rtl/mem_stage_dmem.sv
// -----------------------------------------------------------------------------
// mem_stage_dmem
//
// MEM-stage data memory and PD select for the PA-RISC pipeline.
// This block takes the EX/MEM outputs RB, ALU result, RAM_CTRL and L.
// It produces PD for the MEM/WB register.
//
// Memory:
//   - Byte-addressable, big-endian.
//   - The lowest address of an access holds the most significant byte.
//   - Loads are combinational and have zero latency.
//   - Stores commit on the rising clock edge.
//   - There is no same-cycle store-to-load bypass.
//
// Optional feature (macro MISALIGN_TRAP_EN):
//   - Defined: a misaligned access sets a sticky fault.
//     The first faulting address is latched.
//     The faulting access is suppressed: no write, PD = 0, not counted.
//   - Undefined: the low address bits are forced to alignment.
//     The access proceeds normally and the fault outputs are tied low.
//
// Parameters:
//   ADDR_W : address width; memory depth is 2**ADDR_W bytes
//   CNT_W  : width of each event counter
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset
//   MEM_ALU_OUT_in  in   effective address (low ADDR_W bits); PD source when L = 0
//   MEM_RB_in       in   store data
//   MEM_RAM_CTRL_in in   [3:2] size (00 byte, 01 half, 10 word, 11 none),
//                        [1] RW (1 = store), [0] SE (1 = sign-extend load)
//   MEM_L_in        in   1 = PD takes memory data, 0 = PD takes ALU result
//   PD_out          out  data toward MEM/WB
//   fault_out       out  sticky misaligned-access flag
//   fault_addr_out  out  address of the first faulting access
//   ld_cnt_out      out  saturating count of completed loads
//   st_cnt_out      out  saturating count of completed stores
// -----------------------------------------------------------------------------
module mem_stage_dmem #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       MEM_ALU_OUT_in,
    input  logic [31:0]       MEM_RB_in,
    input  logic [3:0]        MEM_RAM_CTRL_in,
    input  logic              MEM_L_in,
    output logic [31:0]       PD_out,
    output logic              fault_out,
    output logic [ADDR_W-1:0] fault_addr_out,
    output logic [CNT_W-1:0]  ld_cnt_out,
    output logic [CNT_W-1:0]  st_cnt_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_NONE = 2'b11;

    logic [7:0]        mem_q [DEPTH];
    logic [CNT_W-1:0]  ld_cnt_q;
    logic [CNT_W-1:0]  st_cnt_q;

    logic [1:0]        size;
    logic              rw;
    logic              se;
    logic              valid;
    logic              is_load;
    logic              is_store;
    logic              load_ok;
    logic              store_ok;
    logic [ADDR_W-1:0] raw_addr;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [ADDR_W-1:0] addr3;
    logic [7:0]        rd0;
    logic [7:0]        rd1;
    logic [7:0]        rd2;
    logic [7:0]        rd3;
    logic [31:0]       load_data;

    assign size     = MEM_RAM_CTRL_in[3:2];
    assign rw       = MEM_RAM_CTRL_in[1];
    assign se       = MEM_RAM_CTRL_in[0];
    assign valid    = (size != SIZE_NONE);
    assign is_load  = valid & ~rw;
    assign is_store = valid & rw;
    assign raw_addr = MEM_ALU_OUT_in[ADDR_W-1:0];

`ifdef MISALIGN_TRAP_EN
    logic              misaligned;
    logic              fault_q;
    logic [ADDR_W-1:0] fault_addr_q;

    always_comb begin
        misaligned = 1'b0;
        if (size == SIZE_HALF) begin
            misaligned = raw_addr[0];
        end else if (size == SIZE_WORD) begin
            misaligned = |raw_addr[1:0];
        end
    end

    // A faulting access is dropped entirely.
    // It neither writes memory nor counts as a load or store.
    assign addr0    = raw_addr;
    assign load_ok  = is_load & ~misaligned;
    assign store_ok = is_store & ~misaligned;

    // The fault bit is sticky.
    // The address is captured only while the bit is clear, so the first fault wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else if (valid && misaligned) begin
            fault_q <= 1'b1;
            if (!fault_q) begin
                fault_addr_q <= raw_addr;
            end
        end
    end

    assign fault_out      = fault_q;
    assign fault_addr_out = fault_addr_q;
`else
    // Misaligned accesses are silently rounded down to their natural boundary.
    always_comb begin
        addr0 = raw_addr;
        if (size == SIZE_HALF) begin
            addr0 = {raw_addr[ADDR_W-1:1], 1'b0};
        end else if (size == SIZE_WORD) begin
            addr0 = {raw_addr[ADDR_W-1:2], 2'b00};
        end
    end

    assign load_ok        = is_load;
    assign store_ok       = is_store;
    assign fault_out      = 1'b0;
    assign fault_addr_out = '0;
`endif

    // Byte addresses wrap modulo the memory depth.
    assign addr1 = addr0 + ADDR_W'(1);
    assign addr2 = addr0 + ADDR_W'(2);
    assign addr3 = addr0 + ADDR_W'(3);

    assign rd0 = mem_q[addr0];
    assign rd1 = mem_q[addr1];
    assign rd2 = mem_q[addr2];
    assign rd3 = mem_q[addr3];

    // Big-endian assembly of the load result, with optional sign extension.
    always_comb begin
        load_data = 32'h0;
        case (size)
            SIZE_BYTE: load_data = {{24{se & rd0[7]}}, rd0};
            SIZE_HALF: load_data = {{16{se & rd0[7]}}, rd0, rd1};
            SIZE_WORD: load_data = {rd0, rd1, rd2, rd3};
            default:   load_data = 32'h0;
        endcase
    end

    always_comb begin
        PD_out = MEM_ALU_OUT_in;
        if (MEM_L_in) begin
            PD_out = load_ok ? load_data : 32'h0;
        end
    end

    // Store path: write only the bytes covered by the access.
    // The most significant store byte goes to the lowest address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (store_ok) begin
            case (size)
                SIZE_BYTE: begin
                    mem_q[addr0] <= MEM_RB_in[7:0];
                end
                SIZE_HALF: begin
                    mem_q[addr0] <= MEM_RB_in[15:8];
                    mem_q[addr1] <= MEM_RB_in[7:0];
                end
                SIZE_WORD: begin
                    mem_q[addr0] <= MEM_RB_in[31:24];
                    mem_q[addr1] <= MEM_RB_in[23:16];
                    mem_q[addr2] <= MEM_RB_in[15:8];
                    mem_q[addr3] <= MEM_RB_in[7:0];
                end
                default: ;
            endcase
        end
    end

    // Event counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            if (load_ok && (ld_cnt_q != {CNT_W{1'b1}})) begin
                ld_cnt_q <= ld_cnt_q + CNT_W'(1);
            end
            if (store_ok && (st_cnt_q != {CNT_W{1'b1}})) begin
                st_cnt_q <= st_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ld_cnt_out = ld_cnt_q;
    assign st_cnt_out = st_cnt_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
module tb_mem_stage_dmem;

    logic        clk;
    logic        reset;
    logic [31:0] alu;
    logic [31:0] rb;
    logic [3:0]  ctrl;
    logic        l;

    logic [31:0] pd;
    logic        fault;
    logic [7:0]  fault_addr;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    logic [31:0] pd2;
    logic        fault2;
    logic [7:0]  fault_addr2;
    logic [1:0]  ld_cnt2;
    logic [1:0]  st_cnt2;

    int n_checks;
    int n_fail;

    mem_stage_dmem #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .MEM_ALU_OUT_in (alu),
        .MEM_RB_in      (rb),
        .MEM_RAM_CTRL_in(ctrl),
        .MEM_L_in       (l),
        .PD_out         (pd),
        .fault_out      (fault),
        .fault_addr_out (fault_addr),
        .ld_cnt_out     (ld_cnt),
        .st_cnt_out     (st_cnt)
    );

    // A narrow-counter copy that shares the same stimulus, used for saturation checks.
    mem_stage_dmem #(.ADDR_W(8), .CNT_W(2)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .MEM_ALU_OUT_in (alu),
        .MEM_RB_in      (rb),
        .MEM_RAM_CTRL_in(ctrl),
        .MEM_L_in       (l),
        .PD_out         (pd2),
        .fault_out      (fault2),
        .fault_addr_out (fault_addr2),
        .ld_cnt_out     (ld_cnt2),
        .st_cnt_out     (st_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] rb;
        logic        l;
        logic [31:0] pd;
        logic [15:0] ld;
        logic [15:0] st;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    logic        trap;
    logic [15:0] exp_ld;
    logic [15:0] exp_st;

    initial begin
`ifdef MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        n_checks = 0;
        n_fail   = 0;

        //           ctrl     addr          rb            l     pd            ld  st
        vecs[0]  = '{4'b1000, 32'h0000_0010, 32'h0,        1'b1, 32'h0000_0000, 1,  0};
        vecs[1]  = '{4'b1010, 32'h0000_0020, 32'hA1B2C3D4, 1'b0, 32'h0000_0020, 1,  1};
        vecs[2]  = '{4'b0001, 32'h0000_0020, 32'h0,        1'b1, 32'hFFFF_FFA1, 2,  1};
        vecs[3]  = '{4'b0100, 32'h0000_0022, 32'h0,        1'b1, 32'h0000_C3D4, 3,  1};
        vecs[4]  = '{4'b0010, 32'h0000_0021, 32'h0000_0055, 1'b0, 32'h0000_0021, 3,  2};
        vecs[5]  = '{4'b1000, 32'h0000_0020, 32'h0,        1'b1, 32'hA155_C3D4, 4,  2};
        vecs[6]  = '{4'b1010, 32'h0000_00FC, 32'h01020304, 1'b1, 32'h0000_0000, 4,  3};
        vecs[7]  = '{4'b0000, 32'h0000_00FF, 32'h0,        1'b1, 32'h0000_0004, 5,  3};
        vecs[8]  = '{4'b0000, 32'h0000_0000, 32'h0,        1'b1, 32'h0000_0000, 6,  3};
        vecs[9]  = '{4'b0101, 32'h0000_00FE, 32'h0,        1'b1, 32'h0000_0304, 7,  3};
        vecs[10] = '{4'b1000, 32'h0000_00FC, 32'h0,        1'b1, 32'h0102_0304, 8,  3};
        vecs[11] = '{4'b1100, 32'h0000_0020, 32'h0,        1'b1, 32'h0000_0000, 8,  3};
        vecs[12] = '{4'b1110, 32'h0000_1234, 32'hFFFFFFFF, 1'b0, 32'h0000_1234, 8,  3};
        vecs[13] = '{4'b0101, 32'h0000_0020, 32'h0,        1'b1, 32'hFFFF_A155, 9,  3};
        vecs[14] = '{4'b0110, 32'h0000_0022, 32'hFFFFBEEF, 1'b0, 32'h0000_0022, 9,  4};
        vecs[15] = '{4'b1000, 32'h0000_0020, 32'h0,        1'b1, 32'hA155_BEEF, 10, 4};

        reset = 1'b1;
        alu   = 32'h0;
        rb    = 32'h0;
        ctrl  = 4'b1100;
        l     = 1'b0;
        #1;
        check("reset_ld_cnt", {16'h0, ld_cnt}, 32'h0);
        check("reset_st_cnt", {16'h0, st_cnt}, 32'h0);
        check("reset_fault", {31'h0, fault}, 32'h0);
        check("reset_fault_addr", {24'h0, fault_addr}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            ctrl = vecs[i].ctrl;
            alu  = vecs[i].a;
            rb   = vecs[i].rb;
            l    = vecs[i].l;
            #3;
            check($sformatf("vec%0d_pd", i), pd, vecs[i].pd);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ld_cnt", i), {16'h0, ld_cnt}, {16'h0, vecs[i].ld});
            check($sformatf("vec%0d_st_cnt", i), {16'h0, st_cnt}, {16'h0, vecs[i].st});
        end

        // Narrow counters: 10 loads and 4 stores saturate at 3.
        check("sat_ld_cnt2", {30'h0, ld_cnt2}, 32'h3);
        check("sat_st_cnt2", {30'h0, st_cnt2}, 32'h3);

        // Misaligned word store at 0x31.
        ctrl = 4'b1010; alu = 32'h31; rb = 32'hDEADBEEF; l = 1'b0;
        #3 check("mis_st_pd", pd, 32'h31);
        @(posedge clk); #1;
        exp_st = trap ? 16'd4 : 16'd5;
        check("mis_st_fault", {31'h0, fault}, {31'h0, trap});
        check("mis_st_fault_addr", {24'h0, fault_addr}, trap ? 32'h31 : 32'h0);
        check("mis_st_st_cnt", {16'h0, st_cnt}, {16'h0, exp_st});

        // Trap mode leaves 0x30..0x33 untouched.
        // Aligning mode writes the whole word there.
        ctrl = 4'b1000; alu = 32'h30; l = 1'b1;
        #3 check("mis_chk_mem", pd, trap ? 32'h0 : 32'hDEADBEEF);
        @(posedge clk); #1;
        check("mis_chk_ld_cnt", {16'h0, ld_cnt}, 32'd11);

        // A second misaligned access must not move the latched address.
        ctrl = 4'b0100; alu = 32'h41; l = 1'b1;
        #3 check("mis_ld_pd", pd, 32'h0);
        @(posedge clk); #1;
        exp_ld = trap ? 16'd11 : 16'd12;
        check("mis_ld_ld_cnt", {16'h0, ld_cnt}, {16'h0, exp_ld});
        check("mis_ld_fault", {31'h0, fault}, {31'h0, trap});
        check("mis_ld_fault_addr", {24'h0, fault_addr}, trap ? 32'h31 : 32'h0);

        // Mid-cycle reset clears state immediately.
        ctrl = 4'b1000; alu = 32'h20; l = 1'b1;
        #2 check("pre_rst_pd", pd, 32'hA155_BEEF);
        #1 reset = 1'b1;
        #1;
        check("rst_pd", pd, 32'h0);
        check("rst_ld_cnt", {16'h0, ld_cnt}, 32'h0);
        check("rst_st_cnt", {16'h0, st_cnt}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_fault_addr", {24'h0, fault_addr}, 32'h0);
        check("rst_ld_cnt2", {30'h0, ld_cnt2}, 32'h0);

        // While reset is held, L = 0 passes the ALU value through.
        // The pending store must not commit.
        ctrl = 4'b1010; alu = 32'h1234; rb = 32'h11111111; l = 1'b0;
        #1 check("rst_alu_pd", pd, 32'h0000_1234);
        @(posedge clk); #1;
        reset = 1'b0;
        ctrl  = 4'b1000; alu = 32'h34; l = 1'b1;
        #2 check("rst_store_blocked", pd, 32'h0);
        check("rst_store_st_cnt", {16'h0, st_cnt}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
